// File: rtl/seq_pkg.sv
// Shared types and default constants for the sample sequencer.
package seq_pkg;

    localparam int DW_DEF              = 8;
    localparam int SUM_W               = DW_DEF + 2;
    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int DIV_TIMEOUT_DEF     = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LATCH  = 3'd1,
        DSTART = 3'd2,
        DWAIT  = 3'd3,
        ACCUM  = 3'd4,
        SUM    = 3'd5
    } seq_state_t;

endpackage

// File: rtl/sample_seq_ctrl_if.sv
// Datapath-side handshake: random generator and divide-by-3 unit.
interface sample_seq_ctrl_if import seq_pkg::*; #(parameter int DW = DW_DEF) ();

    logic [DW-1:0] rand_val;
    logic          rand_adv;
    logic          div_start;
    logic [DW-1:0] div_operand;
    logic          div_done;
    logic [DW-1:0] div_quot;

    modport master (
        input  rand_val, div_done, div_quot,
        output rand_adv, div_start, div_operand
    );

    modport slave (
        output rand_val, div_done, div_quot,
        input  rand_adv, div_start, div_operand
    );

endinterface

// File: rtl/sample_seq_ctrl_step_debounce.sv
// Step button conditioning: 2-flop synchronizer, stable-level debounce,
// one-cycle press pulse on the debounced 1->0 transition.
module step_debounce import seq_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic step_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync_1;
    logic          sync_2;
    logic          level;
    logic [CW-1:0] cnt;

    // Flops preset to the released level so reset release never looks like a press.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sync_1 <= 1'b1;
            sync_2 <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_1 <= step_n;
            sync_2 <= sync_1;
            press  <= 1'b0;
            if (sync_2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_2;
                cnt   <= '0;
                press <= level;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sample_seq_ctrl.sv
// One controlled pass through the random / divide-by-3 / running-sum datapath
// per debounced step press, with a divider timeout.
//
// state  | meaning
// IDLE   | waiting for a press
// LATCH  | capture rand_val, pulse rand_adv
// DSTART | pulse div_start, present operand, clear timeout
// DWAIT  | wait for div_done or timeout
// ACCUM  | shift quotient into the 3-deep history
// SUM    | publish signed x+y+z, pulse result_valid
module sample_seq_ctrl import seq_pkg::*; #(
    parameter int DW              = DW_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int DIV_TIMEOUT     = DIV_TIMEOUT_DEF
) (
    input  logic                   CLOCK_50,
    input  logic                   rst_n,
    input  logic                   step_n,
    sample_seq_ctrl_if.master      dp,
    output logic [DW-1:0]          rand_latched,
    output logic [DW-1:0]          quot_latched,
    output logic [DW-1:0]          hist_x,
    output logic [DW-1:0]          hist_y,
    output logic [DW-1:0]          hist_z,
    output logic [DW+1:0]          sum_val,
    output logic                   result_valid,
    output logic                   busy,
    output logic                   err,
    output logic [7:0]             sample_cnt
);

    localparam int TW = $clog2(DIV_TIMEOUT + 1);

    seq_state_t    state;
    seq_state_t    state_nxt;
    logic          press;
    logic [TW-1:0] tmo_cnt;
    logic          timeout_hit;

    logic adv_d, start_d, cap_rand, cap_quot, shift_hist, sum_load;
    logic set_err, tmo_clr, tmo_inc;

    step_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .step_n   (step_n),
        .press    (press)
    );

    assign timeout_hit = (tmo_cnt == TW'(DIV_TIMEOUT - 1));
    assign busy        = (state != IDLE);

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (press) state_nxt = LATCH;
            LATCH:   state_nxt = DSTART;
            DSTART:  state_nxt = DWAIT;
            DWAIT: begin
                if (dp.div_done)      state_nxt = ACCUM;
                else if (timeout_hit) state_nxt = IDLE;
            end
            ACCUM:   state_nxt = SUM;
            SUM:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        adv_d      = 1'b0;
        start_d    = 1'b0;
        cap_rand   = 1'b0;
        cap_quot   = 1'b0;
        shift_hist = 1'b0;
        sum_load   = 1'b0;
        set_err    = 1'b0;
        tmo_clr    = 1'b0;
        tmo_inc    = 1'b0;
        case (state)
            LATCH: begin
                cap_rand = 1'b1;
                adv_d    = 1'b1;
            end
            DSTART: begin
                start_d = 1'b1;
                tmo_clr = 1'b1;
            end
            DWAIT: begin
                // done takes priority over a coincident timeout
                if (dp.div_done)      cap_quot = 1'b1;
                else if (timeout_hit) set_err  = 1'b1;
                else                  tmo_inc  = 1'b1;
            end
            ACCUM:   shift_hist = 1'b1;
            SUM:     sum_load   = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            dp.rand_adv    <= 1'b0;
            dp.div_start   <= 1'b0;
            dp.div_operand <= '0;
            rand_latched   <= '0;
            quot_latched   <= '0;
            hist_x         <= '0;
            hist_y         <= '0;
            hist_z         <= '0;
            sum_val        <= '0;
            result_valid   <= 1'b0;
            err            <= 1'b0;
            sample_cnt     <= '0;
            tmo_cnt        <= '0;
        end else begin
            dp.rand_adv  <= adv_d;
            dp.div_start <= start_d;
            result_valid <= sum_load;
            if (cap_rand) rand_latched <= dp.rand_val;
            if (start_d)  dp.div_operand <= rand_latched;
            if (cap_quot) quot_latched <= dp.div_quot;
            if (set_err)  err <= 1'b1;
            if (tmo_clr)      tmo_cnt <= '0;
            else if (tmo_inc) tmo_cnt <= tmo_cnt + 1'b1;
            if (shift_hist) begin
                hist_z <= hist_y;
                hist_y <= hist_x;
                hist_x <= quot_latched;
            end
            // history already shifted by ACCUM, so this sums the new window
            if (sum_load) begin
                sum_val <= {{2{hist_x[DW-1]}}, hist_x}
                         + {{2{hist_y[DW-1]}}, hist_y}
                         + {{2{hist_z[DW-1]}}, hist_z};
                sample_cnt <= sample_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_sample_seq_ctrl.sv
// Scoreboard bench for sample_seq_ctrl: presses push expectations, a negedge
// monitor pops and compares on div_start and result_valid.
module tb_sample_seq_ctrl;
    import seq_pkg::*;

    localparam int DW  = 8;
    localparam int DEB = 8;
    localparam int TMO = 32;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             step_n = 1'b1;
    logic [DW-1:0]    rand_latched, quot_latched, hist_x, hist_y, hist_z;
    logic [SUM_W-1:0] sum_val;
    logic             result_valid, busy, err;
    logic [7:0]       sample_cnt;

    sample_seq_ctrl_if #(.DW(DW)) bus ();

    sample_seq_ctrl #(.DW(DW), .DEBOUNCE_CYCLES(DEB), .DIV_TIMEOUT(TMO)) dut (
        .CLOCK_50     (clk),
        .rst_n        (rst_n),
        .step_n       (step_n),
        .dp           (bus.master),
        .rand_latched (rand_latched),
        .quot_latched (quot_latched),
        .hist_x       (hist_x),
        .hist_y       (hist_y),
        .hist_z       (hist_z),
        .sum_val      (sum_val),
        .result_valid (result_valid),
        .busy         (busy),
        .err          (err),
        .sample_cnt   (sample_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] rv, q, x, y, z, cnt;
        logic [9:0] sum;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] op_q[$];
    logic [7:0] quot_q[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int adv_cnt = 0, start_cnt = 0, rv_cnt = 0;
    int adv_cyc = 0, start_cyc = 0, rv_cyc = 0, err_cyc = 0;
    int div_delay = 3;
    bit div_alive = 1'b1;
    int div_cnt = 0;

    logic [7:0] mx = 0, my = 0, mz = 0, mcnt = 0;
    logic [9:0] msum = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    // divider model: done pulses div_delay cycles after div_start is seen
    initial begin
        bus.div_done = 1'b0;
        bus.div_quot = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                div_cnt = 0;
                bus.div_done = 1'b0;
            end else if (bus.div_start && div_alive) begin
                div_cnt = div_delay;
                bus.div_done = 1'b0;
            end else if (div_cnt > 1) begin
                div_cnt--;
                bus.div_done = 1'b0;
            end else if (div_cnt == 1) begin
                div_cnt = 0;
                bus.div_done = 1'b1;
                if (quot_q.size() > 0) bus.div_quot = quot_q.pop_front();
            end else begin
                bus.div_done = 1'b0;
            end
        end
    end

    // monitor
    initial begin
        logic prev_adv;
        logic prev_err;
        logic [7:0] eop;
        exp_t e;
        prev_adv = 1'b0;
        prev_err = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.rand_adv) begin
                adv_cnt++;
                adv_cyc = cyc;
                chk("rand_adv_width", {31'd0, prev_adv}, 0);
            end
            prev_adv = bus.rand_adv;
            if (bus.div_start) begin
                start_cnt++;
                start_cyc = cyc;
                chk("op_queue_nonempty", {31'd0, op_q.size() > 0}, 1);
                if (op_q.size() > 0) begin
                    eop = op_q.pop_front();
                    chk("div_operand", bus.div_operand, eop);
                end
            end
            if (result_valid) begin
                rv_cnt++;
                rv_cyc = cyc;
                chk("sb_queue_nonempty", {31'd0, exp_q.size() > 0}, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_sum_val", sum_val, e.sum);
                    chk("sb_hist_x", hist_x, e.x);
                    chk("sb_hist_y", hist_y, e.y);
                    chk("sb_hist_z", hist_z, e.z);
                    chk("sb_sample_cnt", sample_cnt, e.cnt);
                    chk("sb_quot_latched", quot_latched, e.q);
                    chk("sb_rand_latched", rand_latched, e.rv);
                end
            end
            if (err && !prev_err) err_cyc = cyc;
            prev_err = err;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        @(negedge clk);
        while (busy && k < 400) begin
            @(negedge clk);
            k++;
        end
        chk(name, {31'd0, busy}, 0);
        tick(1);
    endtask

    task automatic push_expect(input logic [7:0] rv, input logic [7:0] q);
        exp_t e;
        int s;
        quot_q.push_back(q);
        mz = my;
        my = mx;
        mx = q;
        mcnt = mcnt + 8'd1;
        s = $signed(mx) + $signed(my) + $signed(mz);
        msum = s[9:0];
        e.rv = rv; e.q = q; e.x = mx; e.y = my; e.z = mz; e.cnt = mcnt; e.sum = msum;
        exp_q.push_back(e);
    endtask

    task automatic do_press(input logic [7:0] rv, input logic [7:0] q, input bit completes);
        bus.rand_val = rv;
        op_q.push_back(rv);
        if (completes) push_expect(rv, q);
        step_n = 1'b0;
        tick(DEB + 4);
        step_n = 1'b1;
        tick(DEB + 4);
        wait_idle("press_returns_idle");
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int lv[8];
        int dur[8];
        int a0, r0, s0, k;
        lv  = '{0, 1, 0, 1, 0, 1, 0, 1};
        dur = '{DEB - 1, 2, 3, 2, 6, 1, 7, 3};

        bus.rand_val = '0;
        rst_n = 1'b0;
        step_n = 1'b1;
        tick(3);
        chk("rst_sum_val", sum_val, 0);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_rand_adv", {31'd0, bus.rand_adv}, 0);
        chk("rst_sample_cnt", sample_cnt, 0);

        rst_n = 1'b1;
        tick(200);
        chk("idle_adv_cnt", adv_cnt, 0);
        chk("idle_busy", {31'd0, busy}, 0);
        chk("idle_err", {31'd0, err}, 0);
        chk("idle_hist_x", hist_x, 0);

        do_press(8'h60, 8'h20, 1'b1);
        chk("p1_adv_cnt", adv_cnt, 1);
        chk("p1_start_cnt", start_cnt, 1);
        chk("p1_rv_cnt", rv_cnt, 1);
        chk("p1_hist_x", hist_x, 8'h20);
        chk("p1_sum_val", sum_val, 10'h020);
        chk("p1_sample_cnt", sample_cnt, 1);
        chk("p1_adv_to_result", rv_cyc - adv_cyc, 7);
        chk("p1_start_to_result", rv_cyc - start_cyc, 6);

        do_press(8'hA5, 8'hE0, 1'b1);
        do_press(8'h3C, 8'h7F, 1'b1);
        chk("p3_sum_val", sum_val, 10'h07F);
        do_press(8'h01, 8'h80, 1'b1);
        chk("p4_hist_x", hist_x, 8'h80);
        chk("p4_hist_y", hist_y, 8'h7F);
        chk("p4_hist_z", hist_z, 8'hE0);
        chk("p4_sum_val", sum_val, 10'h3DF);
        chk("p4_sample_cnt", sample_cnt, 4);

        // short lows and bounces never reach the debounce threshold
        for (int i = 0; i < 8; i++) begin
            step_n = lv[i][0];
            tick(dur[i]);
        end
        step_n = 1'b1;
        tick(40);
        chk("bounce_adv_cnt", adv_cnt, 4);
        chk("bounce_busy", {31'd0, busy}, 0);

        // second press lands in DWAIT and must be dropped
        div_delay = 25;
        bus.rand_val = 8'h44;
        op_q.push_back(8'h44);
        push_expect(8'h44, 8'h10);
        step_n = 1'b0; tick(12);
        step_n = 1'b1; tick(12);
        step_n = 1'b0; tick(12);
        step_n = 1'b1; tick(12);
        wait_idle("dwait_press_idle");
        tick(40);
        chk("dwait_adv_cnt", adv_cnt, 5);
        chk("dwait_rv_cnt", rv_cnt, 5);
        chk("dwait_sample_cnt", sample_cnt, 5);

        // divider timeout
        div_delay = 3;
        div_alive = 1'b0;
        do_press(8'h77, 8'h00, 1'b0);
        chk("tmo_err", {31'd0, err}, 1);
        chk("tmo_latency", err_cyc - start_cyc, TMO);
        chk("tmo_sum_val", sum_val, msum);
        chk("tmo_hist_x", hist_x, mx);
        chk("tmo_sample_cnt", sample_cnt, 5);
        chk("tmo_rv_cnt", rv_cnt, 5);
        div_alive = 1'b1;
        do_press(8'h12, 8'h05, 1'b1);
        chk("after_tmo_err_sticky", {31'd0, err}, 1);
        chk("after_tmo_sample_cnt", sample_cnt, 6);

        // reset during DWAIT
        div_delay = 25;
        bus.rand_val = 8'h33;
        op_q.push_back(8'h33);
        s0 = start_cnt;
        step_n = 1'b0;
        k = 0;
        while (start_cnt == s0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk("rst_test_start_seen", start_cnt, s0 + 1);
        tick(3);
        rst_n = 1'b0;
        #2;
        chk("async_hist_x", hist_x, 0);
        chk("async_sum_val", sum_val, 0);
        chk("async_sample_cnt", sample_cnt, 0);
        chk("async_err", {31'd0, err}, 0);
        chk("async_busy", {31'd0, busy}, 0);
        chk("async_div_operand", bus.div_operand, 0);
        step_n = 1'b1;
        quot_q.delete();
        exp_q.delete();
        op_q.delete();
        mx = 0; my = 0; mz = 0; mcnt = 0; msum = 0;
        tick(3);
        rst_n = 1'b1;
        a0 = adv_cnt;
        s0 = start_cnt;
        tick(50);
        chk("post_rst_no_adv", adv_cnt, a0);
        chk("post_rst_no_start", start_cnt, s0);
        chk("post_rst_busy", {31'd0, busy}, 0);

        // 256 presses wrap sample_cnt
        div_delay = 3;
        r0 = rv_cnt;
        for (int i = 0; i < 256; i++) begin
            logic [7:0] q;
            q = 8'(i * 37 + 5);
            do_press(i[7:0], q, 1'b1);
        end
        chk("wrap_rv_cnt", rv_cnt - r0, 256);
        chk("wrap_sample_cnt", sample_cnt, 0);
        chk("wrap_exp_q_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
